// File: rtl/sar_search_4_bits_if.sv
// Handshake and data bundle between the SAR search controller and its
// surroundings: START request, comparator flags in, trial/result/status out.
//
// Handshake: START is a level request sampled on the rising clock edge; it is
// accepted only while the controller is idle, and is otherwise ignored with no
// queueing. Completion is signalled by a one-cycle DONE pulse, and RESULT, ERR
// and STEPS are valid in that cycle. They stay held until the next search
// finishes (RESULT) or the next START is accepted (ERR/STEPS).
interface sar_search_4_bits_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = $clog2(WIDTH) + 1
);
    logic              start;
    logic              cmp_equal;
    logic              cmp_less;
    logic              cmp_higher;
    logic [WIDTH-1:0]  guess;
    logic [WIDTH-1:0]  result;
    logic              busy;
    logic              done;
    logic              err;
    logic [STEP_W-1:0] steps;

    // Environment side: raises START and returns the comparator flags.
    modport master (
        output start, cmp_equal, cmp_less, cmp_higher,
        input  guess, result, busy, done, err, steps
    );

    // Controller side.
    modport slave (
        input  start, cmp_equal, cmp_less, cmp_higher,
        output guess, result, busy, done, err, steps
    );
endinterface

// File: rtl/sar_search_4_bits.sv
// Successive-approximation search controller. It drives a trial value (GUESS)
// into an external combinational comparator and uses the EQUAL/LESS/HIGHER
// flags to settle one bit per cycle, MSB first.
//
// Optional feature macro: SAR_EARLY_EXIT_EN. When it is defined, an EQUAL flag
// ends the search at once. When it is undefined, EQUAL keeps the bit like
// HIGHER, and every search takes exactly WIDTH trials.
//
// The state register is exported on state_o (0 idle, 1 trial, 2 done).
module sar_search_4_bits #(
    parameter int WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sar_search_4_bits_if.slave   sar,
    output logic [1:0]           state_o
);
    localparam int STEP_W = $clog2(WIDTH) + 1;
    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRIAL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  guess_q;
    logic [WIDTH-1:0]  result_q;
    logic [IDX_W-1:0]  idx_q;
    logic [STEP_W-1:0] steps_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              flags_ok_d;
    logic              early_hit_d;
    logic [IDX_W-1:0]  idx_dec_d;
    logic [WIDTH-1:0]  kept_guess_d;
    logic [WIDTH-1:0]  next_guess_d;

    // Decide the current bit from the flags and prepare the next trial value.
    always_comb begin
        flags_ok_d = 1'b0;
        case ({sar.cmp_equal, sar.cmp_less, sar.cmp_higher})
            3'b100, 3'b010, 3'b001: flags_ok_d = 1'b1;
            default:                flags_ok_d = 1'b0;
        endcase

`ifdef SAR_EARLY_EXIT_EN
        early_hit_d = sar.cmp_equal;
`else
        early_hit_d = 1'b0;
`endif

        // Target below the guess means the bit under test overshoots.
        kept_guess_d = guess_q;
        if (sar.cmp_less) begin
            kept_guess_d[idx_q] = 1'b0;
        end

        idx_dec_d    = idx_q - IDX_W'(1);
        next_guess_d = kept_guess_d;
        if (idx_q != '0) begin
            next_guess_d[idx_dec_d] = 1'b1;
        end
    end

    // Search FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            guess_q  <= '0;
            result_q <= '0;
            idx_q    <= IDX_W'(WIDTH - 1);
            steps_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sar.start) begin
                        guess_q <= WIDTH'(1) << (WIDTH - 1);
                        idx_q   <= IDX_W'(WIDTH - 1);
                        steps_q <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_TRIAL;
                    end
                end

                ST_TRIAL: begin
                    steps_q <= steps_q + STEP_W'(1);
                    if (!flags_ok_d) begin
                        // Inconsistent comparator: abandon with a zero result.
                        err_q    <= 1'b1;
                        result_q <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else if (early_hit_d) begin
                        result_q <= guess_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else if (idx_q == '0) begin
                        guess_q  <= kept_guess_d;
                        result_q <= kept_guess_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        guess_q <= next_guess_d;
                        idx_q   <= idx_dec_d;
                    end
                end

                ST_DONE: begin
                    // START is deliberately not looked at here.
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sar.guess  = guess_q;
    assign sar.result = result_q;
    assign sar.busy   = busy_q;
    assign sar.done   = done_q;
    assign sar.err    = err_q;
    assign sar.steps  = steps_q;
    assign state_o    = state_q;
endmodule

// File: tb/tb_sar_search_4_bits.sv
// Bench for sar_search_4_bits. A behavioural comparator sits between GUESS
// and the flags, and can be overridden to inject inconsistent flags. Each
// search is expanded into an expected per-cycle output trace. The trace is
// computed from the binary-search arithmetic: the k-th trial is the target's
// top k bits plus a single 1 below them. A single compare process checks
// that trace one step after every rising edge.
module tb_sar_search_4_bits;
    localparam int W  = 4;
    localparam int SW = $clog2(W) + 1;

    typedef struct {
        logic [W-1:0]  guess;
        logic [W-1:0]  result;
        logic          busy;
        logic          done;
        logic          err;
        logic [SW-1:0] steps;
        bit            lit_en;
        logic [W-1:0]  lit_result;
        logic [SW-1:0] lit_steps;
        logic          lit_err;
    } rec_t;

    logic         clk;
    logic         rst;
    logic [1:0]   state_dbg;
    logic [W-1:0] target;
    logic         force_bad;
    logic [2:0]   bad_pat;    // {equal, less, higher}
    bit           finish_req;
    logic [W-1:0] exp_result;

    rec_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    sar_search_4_bits_if #(.WIDTH(W)) sar ();

    sar_search_4_bits #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .sar     (sar),
        .state_o (state_dbg)
    );

    // Clock and reset-related defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural comparator: target on PORT_A, GUESS on PORT_B.
    always_comb begin
        if (force_bad) begin
            {sar.cmp_equal, sar.cmp_less, sar.cmp_higher} = bad_pat;
        end else begin
            sar.cmp_equal  = (target == sar.guess);
            sar.cmp_less   = (target <  sar.guess);
            sar.cmp_higher = (target >  sar.guess);
        end
    end

    // k-th trial value of an ideal MSB-first search for tgt.
    function automatic logic [W-1:0] trial_value(input logic [W-1:0] tgt, input int k);
        int base;
        base = (int'(tgt) >> (W - k)) << (W - k);
        return W'(base | (1 << (W - 1 - k)));
    endfunction

    function automatic rec_t mk_rec(input logic [W-1:0] g, input logic [W-1:0] r,
                                    input logic b, input logic d, input logic e,
                                    input int s);
        rec_t x;
        x.guess = g; x.result = r; x.busy = b; x.done = d; x.err = e;
        x.steps = SW'(s);
        x.lit_en = 1'b0; x.lit_result = '0; x.lit_steps = '0; x.lit_err = 1'b0;
        return x;
    endfunction

    // Driver: one search. bad >= 0 injects bad_pat during that trial.
    // hold keeps START high through the busy and done cycles.
    task automatic run_search(input logic [W-1:0] tgt, input bit hold,
                              input int bad, input logic [2:0] pat,
                              input bit lit_en, input logic [W-1:0] lit_r,
                              input int lit_s, input logic lit_e);
        logic [W-1:0] g[W];
        int           n_nat;
        int           n;
        int           bad_eff;
        logic         e;
        logic [W-1:0] res;
        logic [W-1:0] fin;
        rec_t         d;
        for (int k = 0; k < W; k++) g[k] = trial_value(tgt, k);
        n_nat = W;
`ifdef SAR_EARLY_EXIT_EN
        for (int k = W - 1; k >= 0; k--) if (g[k] == tgt) n_nat = k + 1;
`endif
        if (bad >= 0 && bad < n_nat) begin
            bad_eff = bad; n = bad + 1; e = 1'b1; res = '0; fin = g[bad];
        end else begin
            bad_eff = -1; n = n_nat; e = 1'b0; res = tgt; fin = tgt;
        end

        @(negedge clk);
        target = tgt;
        bad_pat = pat;
        sar.start = 1'b1;
        for (int k = 0; k < n; k++) exp_q.push_back(mk_rec(g[k], exp_result, 1'b1, 1'b0, 1'b0, k));
        d = mk_rec(fin, res, 1'b0, 1'b1, e, n);
        d.lit_en = lit_en; d.lit_result = lit_r; d.lit_steps = SW'(lit_s); d.lit_err = lit_e;
        exp_q.push_back(d);
        exp_q.push_back(mk_rec(fin, res, 1'b0, 1'b0, e, n));
        exp_result = res;

        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clk);
            sar.start = hold && (c <= n + 1);
            force_bad = (c == bad_eff + 1);
        end
        force_bad = 1'b0;
        sar.start = 1'b0;
    endtask

    // Driver: reset asserted during the second trial cycle.
    task automatic run_reset_abort(input logic [W-1:0] tgt);
        @(negedge clk);
        target = tgt;
        sar.start = 1'b1;
        exp_q.push_back(mk_rec(trial_value(tgt, 0), exp_result, 1'b1, 1'b0, 1'b0, 0));
        exp_q.push_back(mk_rec(trial_value(tgt, 1), exp_result, 1'b1, 1'b0, 1'b0, 1));
        exp_q.push_back(mk_rec('0, '0, 1'b0, 1'b0, 1'b0, 0));
        exp_q.push_back(mk_rec('0, '0, 1'b0, 1'b0, 1'b0, 0));
        exp_result = '0;
        @(negedge clk); sar.start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard: one expected record per cycle, plus watchdog and report.
    initial begin
        rec_t r;
        int   cyc;
        int   drain;
        cyc = 0;
        drain = 0;
        n_cmp = 0;
        n_bad = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                n_cmp++;
                if (sar.guess !== r.guess || sar.result !== r.result || sar.busy !== r.busy ||
                    sar.done !== r.done || sar.err !== r.err || sar.steps !== r.steps) begin
                    n_bad++;
                    $display("FAIL trace cyc=%0d got guess=%b result=%b busy=%b done=%b err=%b steps=%0d want guess=%b result=%b busy=%b done=%b err=%b steps=%0d",
                             cyc, sar.guess, sar.result, sar.busy, sar.done, sar.err, sar.steps,
                             r.guess, r.result, r.busy, r.done, r.err, r.steps);
                end
                if (r.lit_en) begin
                    n_cmp++;
                    if (sar.done !== 1'b1 || sar.result !== r.lit_result ||
                        sar.steps !== r.lit_steps || sar.err !== r.lit_err) begin
                        n_bad++;
                        $display("FAIL pinned cyc=%0d got done=%b result=%b steps=%0d err=%b want done=1 result=%b steps=%0d err=%b",
                                 cyc, sar.done, sar.result, sar.steps, sar.err,
                                 r.lit_result, r.lit_steps, r.lit_err);
                    end
                end
            end
            if (finish_req) drain++;
            if (finish_req && exp_q.size() == 0) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
            if (cyc > 20000 || drain > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL watchdog cyc=%0d pending=%0d want pending=0", cyc, exp_q.size());
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    // Stimulus.
    initial begin
        int          bad;
        logic [2:0]  pats [5];
        pats[0] = 3'b000; pats[1] = 3'b011; pats[2] = 3'b101;
        pats[3] = 3'b110; pats[4] = 3'b111;
        rst = 1'b1;
        sar.start = 1'b0;
        force_bad = 1'b0;
        bad_pat = 3'b000;
        target = '0;
        finish_req = 1'b0;
        exp_result = '0;

        // Reset state, then idle after release.
        repeat (2) @(negedge clk);
        exp_q.push_back(mk_rec('0, '0, 1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(mk_rec('0, '0, 1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);

        // Hand-computed cases.
        run_search(4'b1011, 1'b0, -1, 3'b000, 1'b1, 4'b1011, 4, 1'b0);
`ifdef SAR_EARLY_EXIT_EN
        run_search(4'b1000, 1'b0, -1, 3'b000, 1'b1, 4'b1000, 1, 1'b0);
`else
        run_search(4'b1000, 1'b0, -1, 3'b000, 1'b1, 4'b1000, 4, 1'b0);
`endif
        run_search(4'b0000, 1'b0, -1, 3'b000, 1'b1, 4'b0000, 4, 1'b0);
        run_search(4'b1111, 1'b0, -1, 3'b000, 1'b1, 4'b1111, 4, 1'b0);
        run_search(4'b0110, 1'b0, 0, 3'b011, 1'b1, 4'b0000, 1, 1'b1);
        run_search(4'b0101, 1'b0, -1, 3'b000, 1'b1, 4'b0101, 4, 1'b0);
        run_search(4'b0111, 1'b1, -1, 3'b000, 1'b1, 4'b0111, 4, 1'b0);
        run_reset_abort(4'b0011);
        run_search(4'b1101, 1'b0, -1, 3'b000, 1'b1, 4'b1101, 4, 1'b0);

        // Randomized searches, some with START held and some with bad flags.
        for (int i = 0; i < 40; i++) begin
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            run_search(W'($urandom_range(0, (1 << W) - 1)), bit'($urandom_range(0, 1)),
                       bad, pats[$urandom_range(0, 4)], 1'b0, '0, 0, 1'b0);
        end

        finish_req = 1'b1;
    end
endmodule
